uvmt_st_stream_chkr: RTL and testbench

Parametrised, synthesizable checker for the self-testing DUT wrapper bench. It generalises the single tx/rx assertion checker to NUM_CH independent loopback channels. Per channel, it buffers every transmitted word in an expected-data FIFO and compares it in order against received words. It also reports mismatches, overflow, underflow and latency-bound violations through sticky flags and saturating counters. It sits beside the DUT wrapper in the testbench top, driven by the tx/rx interface signals.

---
 rtl/uvmt_st_stream_chkr.sv | 176 +++++++++++++++++
 tb/tb_uvmt_st_stream_chkr.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uvmt_st_stream_chkr.sv
// Stream loopback checker. Each channel keeps an in-order FIFO of transmitted
// words and compares it with received words. Mismatch, overflow, underflow and
// head-latency violations are reported as sticky flags and saturating counters.
module uvmt_st_stream_chkr #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int MAX_LAT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  enable_i,
    input  logic                                  clear_i,
    input  logic [NUM_CH-1:0]                     tx_valid_i,
    input  logic [NUM_CH*DATA_W-1:0]              tx_data_i,
    input  logic [NUM_CH-1:0]                     rx_valid_i,
    input  logic [NUM_CH*DATA_W-1:0]              rx_data_i,
    output logic [NUM_CH-1:0]                     err_mismatch_o,
    output logic [NUM_CH-1:0]                     err_overflow_o,
    output logic [NUM_CH-1:0]                     err_underflow_o,
    output logic [NUM_CH-1:0]                     err_timeout_o,
    output logic                                  err_any_o,
    output logic [NUM_CH*CNT_W-1:0]               match_cnt_o,
    output logic [CNT_W-1:0]                      err_cnt_o,
    output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]   pending_o,
    output logic                                  idle_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int AGE_W = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int EV_W  = $clog2(4 * NUM_CH + 1);
    localparam int SUM_W = CNT_W + EV_W;

    localparam logic [AGE_W-1:0] AGE_MAX  = (MAX_LAT > 0) ? AGE_W'(MAX_LAT) : '0;
    localparam logic [AGE_W-1:0] AGE_LAST = (MAX_LAT > 0) ? AGE_W'(MAX_LAT - 1) : '0;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [SUM_W-1:0] CNT_MAX  = {{EV_W{1'b0}}, {CNT_W{1'b1}}};

    // Per-channel error event count for this cycle, summed into err_cnt.
    logic [2:0]        ev_num [NUM_CH];
    logic [NUM_CH-1:0] ch_empty;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
        logic [OCC_W-1:0]  count_q, count_d;
        logic [AGE_W-1:0]  age_q, age_d;
        logic [CNT_W-1:0]  match_q, match_d;
        logic              mis_q, mis_d, ovf_q, ovf_d, unf_q, unf_d, tmo_q, tmo_d;
        logic [DATA_W-1:0] tx_word, rx_word, head;
        logic              push_req, rx_req, empty, full, pop, push;
        logic              hit, mis_ev, ovf_ev, unf_ev, tmo_ev;

        // Classify this cycle's channel activity and compute next state.
        always_comb begin
            tx_word  = tx_data_i[gi*DATA_W +: DATA_W];
            rx_word  = rx_data_i[gi*DATA_W +: DATA_W];
            head     = mem_q[rd_ptr_q];
            push_req = enable_i & tx_valid_i[gi];
            rx_req   = enable_i & rx_valid_i[gi];
            empty    = (count_q == '0);
            full     = (count_q == OCC_FULL);
            pop      = rx_req & ~empty;
            unf_ev   = rx_req & empty;
            ovf_ev   = push_req & full & ~pop;
            push     = push_req & ~ovf_ev;
            hit      = pop & (head == rx_word);
            mis_ev   = pop & (head != rx_word);
            // Fires only on the cycle the age steps onto MAX_LAT.
            tmo_ev   = (MAX_LAT > 0) && enable_i && !empty && !pop && (age_q == AGE_LAST);

            rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
            wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            count_d  = count_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            age_d = age_q;
            if (enable_i) begin
                if (empty || pop) begin
                    age_d = '0;
                end else if (age_q != AGE_MAX) begin
                    age_d = age_q + 1'b1;
                end
            end

            mis_d   = mis_q | mis_ev;
            ovf_d   = ovf_q | ovf_ev;
            unf_d   = unf_q | unf_ev;
            tmo_d   = tmo_q | tmo_ev;
            match_d = (hit && (match_q != '1)) ? match_q + 1'b1 : match_q;
            if (clear_i) begin
                mis_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                tmo_d   = 1'b0;
                match_d = '0;
            end
        end

        // Channel control state, flags and match counter.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                age_q    <= '0;
                match_q  <= '0;
                mis_q    <= 1'b0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
                tmo_q    <= 1'b0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
                age_q    <= age_d;
                match_q  <= match_d;
                mis_q    <= mis_d;
                ovf_q    <= ovf_d;
                unf_q    <= unf_d;
                tmo_q    <= tmo_d;
            end
        end

        // Expected-data storage; contents are qualified by count, so no reset.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_q[wr_ptr_q] <= tx_word;
            end
        end

        assign ev_num[gi] = 3'(mis_ev) + 3'(unf_ev) + 3'(ovf_ev) + 3'(tmo_ev);
        assign ch_empty[gi]        = (count_q == '0);
        assign err_mismatch_o[gi]  = mis_q;
        assign err_overflow_o[gi]  = ovf_q;
        assign err_underflow_o[gi] = unf_q;
        assign err_timeout_o[gi]   = tmo_q;
        assign match_cnt_o[gi*CNT_W +: CNT_W] = match_q;
        assign pending_o[gi*OCC_W +: OCC_W]   = count_q;
    end

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [SUM_W-1:0] err_sum;

    // Add all channels' error events to the global counter with saturation.
    always_comb begin
        err_sum = SUM_W'(err_cnt_q);
        for (int i = 0; i < NUM_CH; i++) begin
            err_sum = err_sum + SUM_W'(ev_num[i]);
        end
        err_cnt_d = (err_sum > CNT_MAX) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        if (clear_i) begin
            err_cnt_d = '0;
        end
    end

    // Global error counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
    assign err_any_o = |{err_mismatch_o, err_overflow_o, err_underflow_o, err_timeout_o};
    assign idle_o    = &ch_empty;

endmodule

// File: tb/tb_uvmt_st_stream_chkr.sv
// Self-checking bench for uvmt_st_stream_chkr: a queue-based scoreboard tracks
// expected words and counters every cycle, a vector table covers the
// mismatch/underflow cases, and directed sequences cover multi-cycle corners.
module tb_uvmt_st_stream_chkr;

    localparam int NCH     = 2;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int MAX_LAT = 64;
    localparam int CW      = 16;
    localparam int OW      = $clog2(DEPTH) + 1;
    localparam int CMAX    = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               reset_i, enable_i, clear_i;
    logic [NCH-1:0]     tx_valid_i, rx_valid_i;
    logic [NCH*DW-1:0]  tx_data_i, rx_data_i;
    logic [NCH-1:0]     err_mismatch_o, err_overflow_o, err_underflow_o, err_timeout_o;
    logic               err_any_o, idle_o;
    logic [NCH*CW-1:0]  match_cnt_o;
    logic [CW-1:0]      err_cnt_o;
    logic [NCH*OW-1:0]  pending_o;

    uvmt_st_stream_chkr #(
        .NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .MAX_LAT(MAX_LAT), .CNT_W(CW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .clear_i        (clear_i),
        .tx_valid_i     (tx_valid_i),
        .tx_data_i      (tx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_data_i      (rx_data_i),
        .err_mismatch_o (err_mismatch_o),
        .err_overflow_o (err_overflow_o),
        .err_underflow_o(err_underflow_o),
        .err_timeout_o  (err_timeout_o),
        .err_any_o      (err_any_o),
        .match_cnt_o    (match_cnt_o),
        .err_cnt_o      (err_cnt_o),
        .pending_o      (pending_o),
        .idle_o         (idle_o)
    );

    always #5 clk = ~clk;

    // Scoreboard / reference state.
    logic [DW-1:0] mq [NCH][$];
    int            m_age   [NCH];
    int            m_match [NCH];
    int            m_err;
    logic [NCH-1:0] m_mis, m_ovf, m_unf, m_tmo;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0]  txv;
        logic [31:0] tx0;
        logic [31:0] tx1;
        logic [1:0]  rxv;
        logic [31:0] rx0;
        logic [31:0] rx1;
        logic [1:0]  exp_mis;
        logic [1:0]  exp_unf;
        logic [3:0]  exp_p0;
        logic [3:0]  exp_p1;
        logic [15:0] exp_err;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_age[c]   = 0;
            m_match[c] = 0;
        end
        m_err = 0;
        m_mis = '0;
        m_ovf = '0;
        m_unf = '0;
        m_tmo = '0;
    endtask

    task automatic model_update();
        int ev;
        logic [DW-1:0] txd, rxd;
        bit empty, full, pop, unf, ovf, tmo, push;
        ev = 0;
        for (int c = 0; c < NCH; c++) begin
            txd   = tx_data_i[c*DW +: DW];
            rxd   = rx_data_i[c*DW +: DW];
            empty = (mq[c].size() == 0);
            full  = (mq[c].size() == DEPTH);
            pop   = enable_i && rx_valid_i[c] && !empty;
            unf   = enable_i && rx_valid_i[c] && empty;
            ovf   = enable_i && tx_valid_i[c] && full && !pop;
            push  = enable_i && tx_valid_i[c] && !ovf;
            tmo   = enable_i && !empty && !pop && (m_age[c] == MAX_LAT - 1);
            if (enable_i) begin
                if (empty || pop) m_age[c] = 0;
                else if (m_age[c] < MAX_LAT) m_age[c]++;
            end
            if (pop) begin
                if (mq[c][0] == rxd) begin
                    if (m_match[c] < CMAX) m_match[c]++;
                end else begin
                    m_mis[c] = 1'b1;
                    ev++;
                end
                void'(mq[c].pop_front());
            end
            if (unf) begin m_unf[c] = 1'b1; ev++; end
            if (ovf) begin m_ovf[c] = 1'b1; ev++; end
            if (tmo) begin m_tmo[c] = 1'b1; ev++; end
            if (push) mq[c].push_back(txd);
        end
        m_err = (m_err + ev > CMAX) ? CMAX : m_err + ev;
        if (clear_i) begin
            m_err = 0;
            m_mis = '0;
            m_ovf = '0;
            m_unf = '0;
            m_tmo = '0;
            for (int c = 0; c < NCH; c++) m_match[c] = 0;
        end
    endtask

    task automatic check_all();
        logic [NCH*CW-1:0] exp_match;
        logic [NCH*OW-1:0] exp_pend;
        bit all_empty;
        all_empty = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            exp_match[c*CW +: CW] = CW'(m_match[c]);
            exp_pend[c*OW +: OW]  = OW'(mq[c].size());
            if (mq[c].size() != 0) all_empty = 1'b0;
        end
        chk("err_mismatch",  64'(err_mismatch_o),  64'(m_mis));
        chk("err_overflow",  64'(err_overflow_o),  64'(m_ovf));
        chk("err_underflow", 64'(err_underflow_o), 64'(m_unf));
        chk("err_timeout",   64'(err_timeout_o),   64'(m_tmo));
        chk("err_any",       64'(err_any_o),       64'(|{m_mis, m_ovf, m_unf, m_tmo}));
        chk("match_cnt",     64'(match_cnt_o),     64'(exp_match));
        chk("err_cnt",       64'(err_cnt_o),       64'(CW'(m_err)));
        chk("pending",       64'(pending_o),       64'(exp_pend));
        chk("idle",          64'(idle_o),          64'(all_empty));
    endtask

    // One clock: update the model from the inputs now applied, then compare.
    task automatic tick();
        if (reset_i) model_reset();
        else model_update();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b en=%b clr=%b txv=%b rxv=%b pend=%h err_cnt=%0d match=%h",
                 $time, reset_i, enable_i, clear_i, tx_valid_i, rx_valid_i,
                 pending_o, err_cnt_o, match_cnt_o);
        check_all();
    endtask

    task automatic idle_inputs();
        enable_i   = 1'b1;
        clear_i    = 1'b0;
        tx_valid_i = '0;
        rx_valid_i = '0;
        tx_data_i  = '0;
        rx_data_i  = '0;
    endtask

    initial begin
        vecs[0] = '{2'b10, 32'h0, 32'h0000_0001, 2'b00, 32'h0, 32'h0,         2'b00, 2'b00, 4'd0, 4'd1, 16'd0};
        vecs[1] = '{2'b00, 32'h0, 32'h0,         2'b10, 32'h0, 32'hDEAD_BEEF, 2'b10, 2'b00, 4'd0, 4'd0, 16'd1};
        vecs[2] = '{2'b10, 32'h0, 32'h0000_0011, 2'b10, 32'h0, 32'h0000_0022, 2'b10, 2'b10, 4'd0, 4'd1, 16'd2};
        vecs[3] = '{2'b01, 32'h5, 32'h0,         2'b10, 32'h0, 32'h0000_0011, 2'b10, 2'b10, 4'd1, 4'd0, 16'd2};
        vecs[4] = '{2'b00, 32'h0, 32'h0,         2'b01, 32'h5, 32'h0,         2'b10, 2'b10, 4'd0, 4'd0, 16'd2};

        idle_inputs();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        chk("reset_idle", 64'(idle_o), 64'd1);
        chk("reset_err_cnt", 64'(err_cnt_o), 64'd0);
        tick();

        // Burst of 8 words on ch0, returned 3 cycles later.
        for (int k = 0; k < 11; k++) begin
            idle_inputs();
            if (k < 8) begin
                tx_valid_i[0]   = 1'b1;
                tx_data_i[31:0] = 32'hA5A5_0001 + 32'(k);
            end
            if (k >= 3) begin
                rx_valid_i[0]   = 1'b1;
                rx_data_i[31:0] = 32'hA5A5_0001 + 32'(k - 3);
            end
            tick();
        end
        chk("burst_match0", 64'(match_cnt_o[15:0]), 64'd8);
        chk("burst_err_any", 64'(err_any_o), 64'd0);
        chk("burst_idle", 64'(idle_o), 64'd1);

        // Vector table: mismatch, same-cycle underflow, matches.
        for (int v = 0; v < 5; v++) begin
            idle_inputs();
            tx_valid_i = vecs[v].txv;
            tx_data_i  = {vecs[v].tx1, vecs[v].tx0};
            rx_valid_i = vecs[v].rxv;
            rx_data_i  = {vecs[v].rx1, vecs[v].rx0};
            tick();
            chk("vec_mismatch",  64'(err_mismatch_o),  64'(vecs[v].exp_mis));
            chk("vec_underflow", 64'(err_underflow_o), 64'(vecs[v].exp_unf));
            chk("vec_pending0",  64'(pending_o[3:0]),  64'(vecs[v].exp_p0));
            chk("vec_pending1",  64'(pending_o[7:4]),  64'(vecs[v].exp_p1));
            chk("vec_err_cnt",   64'(err_cnt_o),       64'(vecs[v].exp_err));
        end

        // Overflow: 9 pushes into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            tx_valid_i[0]   = 1'b1;
            tx_data_i[31:0] = 32'h0000_0100 + 32'(i);
            tick();
        end
        chk("ovf_flag", 64'(err_overflow_o[0]), 64'd1);
        chk("ovf_pending0", 64'(pending_o[3:0]), 64'd8);
        chk("ovf_err_cnt", 64'(err_cnt_o), 64'd3);

        // Clear with three errors logged; FIFO contents survive.
        idle_inputs();
        clear_i = 1'b1;
        tick();
        chk("clr_err_cnt", 64'(err_cnt_o), 64'd0);
        chk("clr_err_any", 64'(err_any_o), 64'd0);
        chk("clr_pending0", 64'(pending_o[3:0]), 64'd8);

        // Full FIFO with simultaneous push and pop: no error, count unchanged.
        idle_inputs();
        tx_valid_i[0]   = 1'b1;
        tx_data_i[31:0] = 32'h0000_0200;
        rx_valid_i[0]   = 1'b1;
        rx_data_i[31:0] = 32'h0000_0100;
        tick();
        chk("full_pp_pending0", 64'(pending_o[3:0]), 64'd8);
        chk("full_pp_overflow", 64'(err_overflow_o[0]), 64'd0);

        // Drain with matching words.
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            rx_valid_i[0]   = 1'b1;
            rx_data_i[31:0] = (i < 7) ? 32'h0000_0101 + 32'(i) : 32'h0000_0200;
            tick();
        end
        chk("drain_match0", 64'(match_cnt_o[15:0]), 64'd9);
        chk("drain_err_cnt", 64'(err_cnt_o), 64'd0);

        // Timeout on ch1: flag exactly MAX_LAT edges after the push edge.
        idle_inputs();
        tx_valid_i[1]    = 1'b1;
        tx_data_i[63:32] = 32'h0BAD_F00D;
        tick();
        idle_inputs();
        for (int i = 0; i < MAX_LAT - 1; i++) tick();
        chk("tmo_before", 64'(err_timeout_o[1]), 64'd0);
        tick();
        chk("tmo_at", 64'(err_timeout_o[1]), 64'd1);
        chk("tmo_err_cnt", 64'(err_cnt_o), 64'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("tmo_err_cnt_hold", 64'(err_cnt_o), 64'd1);
        rx_valid_i[1]    = 1'b1;
        rx_data_i[63:32] = 32'h0BAD_F00D;
        tick();
        chk("tmo_late_match1", 64'(match_cnt_o[31:16]), 64'd1);

        // Disabled cycles ignore valids.
        idle_inputs();
        enable_i   = 1'b0;
        tx_valid_i = 2'b11;
        rx_valid_i = 2'b11;
        tick();
        tick();
        chk("disabled_idle", 64'(idle_o), 64'd1);

        // Reset mid-burst discards buffered words without flagging errors.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            tx_valid_i = 2'b11;
            tx_data_i  = {32'h7000_0000 + 32'(i), 32'h6000_0000 + 32'(i)};
            tick();
        end
        reset_i = 1'b1;
        tick();
        chk("rst_mid_idle", 64'(idle_o), 64'd1);
        chk("rst_mid_pending", 64'(pending_o), 64'd0);
        chk("rst_mid_err_any", 64'(err_any_o), 64'd0);
        chk("rst_mid_match", 64'(match_cnt_o), 64'd0);
        reset_i = 1'b0;
        idle_inputs();
        tick();

        // Random traffic, mostly correct returns with occasional corruption.
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            enable_i = ($urandom_range(0, 7) != 0);
            clear_i  = ($urandom_range(0, 63) == 0);
            for (int c = 0; c < NCH; c++) begin
                tx_valid_i[c] = ($urandom_range(0, 2) == 0);
                tx_data_i[c*DW +: DW] = $urandom;
                rx_valid_i[c] = ($urandom_range(0, 2) == 0);
                if (mq[c].size() != 0 && $urandom_range(0, 15) != 0)
                    rx_data_i[c*DW +: DW] = mq[c][0];
                else
                    rx_data_i[c*DW +: DW] = $urandom;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
